// File: rtl/overlay_action_sequencer.sv
// Turns the entropy-overlay state into pipeline stall, flush handshake and lock control.
// Outputs are registered from the next state, so they track seq_state one cycle after fsm_state.
module overlay_action_sequencer #(
  parameter int unsigned MIN_STALL     = 4,
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned ACK_TIMEOUT   = 32,
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned UNLOCK_QUAL   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] fsm_state,
  input  logic       flush_ack,
  input  logic       clr_stats,
  output logic       pipe_stall,
  output logic       flush_req,
  output logic       lock_active,
  output logic       escalate_pulse,
  output logic       flush_fault,
  output logic [2:0] seq_state,
  output logic [7:0] flush_count,
  output logic [7:0] lock_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STAT_W = 8;

  localparam logic [CNT_W-1:0]  MIN_LAST   = CNT_W'(MIN_STALL - 1);
  localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  QUAL_LAST  = CNT_W'(UNLOCK_QUAL - 1);
  localparam logic [STAT_W-1:0] STAT_MAX   = '1;

  localparam logic [1:0] IN_OK    = 2'b00;
  localparam logic [1:0] IN_STALL = 2'b01;
  localparam logic [1:0] IN_FLUSH = 2'b10;
  localparam logic [1:0] IN_LOCK  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE        = 3'b000,
    S_STALL_HOLD  = 3'b001,
    S_FLUSH_REQ   = 3'b010,
    S_FLUSH_DRAIN = 3'b011,
    S_FLUSH_HOLD  = 3'b100,
    S_LOCKED      = 3'b101
  } seq_t;

  seq_t              state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  qual_q, qual_d;
  logic              esc_c, timeout_c;

  logic              pipe_stall_d, flush_req_d, lock_active_d, escalate_d, flush_fault_d;
  logic [STAT_W-1:0] flush_count_d, lock_count_d;

  // Priority LOCK > FLUSH > STALL > OK
  function automatic seq_t dispatch(input logic [1:0] f);
    case (f)
      IN_LOCK:  dispatch = S_LOCKED;
      IN_FLUSH: dispatch = S_FLUSH_REQ;
      IN_STALL: dispatch = S_STALL_HOLD;
      default:  dispatch = S_IDLE;
    endcase
  endfunction

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      qual_q         <= '0;
      pipe_stall     <= 1'b0;
      flush_req      <= 1'b0;
      lock_active    <= 1'b0;
      escalate_pulse <= 1'b0;
      flush_fault    <= 1'b0;
      seq_state      <= 3'b000;
      flush_count    <= '0;
      lock_count     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      qual_q         <= qual_d;
      pipe_stall     <= pipe_stall_d;
      flush_req      <= flush_req_d;
      lock_active    <= lock_active_d;
      escalate_pulse <= escalate_d;
      flush_fault    <= flush_fault_d;
      seq_state      <= 3'(state_d);
      flush_count    <= flush_count_d;
      lock_count     <= lock_count_d;
    end
  end

  // Next state plus dwell/qualification counters
  always_comb begin
    state_d   = state_q;
    esc_c     = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      S_IDLE: state_d = dispatch(fsm_state);
      S_STALL_HOLD: begin
        if (fsm_state == IN_LOCK)                          state_d = S_LOCKED;
        else if (fsm_state == IN_FLUSH)                    state_d = S_FLUSH_REQ;
        else if (fsm_state == IN_OK && cnt_q >= MIN_LAST)  state_d = S_IDLE;
        else if (fsm_state == IN_STALL && cnt_q == STALL_LAST) begin
          state_d = S_FLUSH_REQ;
          esc_c   = 1'b1;
        end
      end
      S_FLUSH_REQ: begin
        if (flush_ack) state_d = S_FLUSH_DRAIN;
        else if (cnt_q == ACK_LAST) begin
          state_d   = S_LOCKED;
          timeout_c = 1'b1;
        end
      end
      S_FLUSH_DRAIN: begin
        // A still-asserted FLUSH parks in FLUSH_HOLD rather than flushing again
        if (cnt_q == DRAIN_LAST)
          state_d = (fsm_state == IN_FLUSH) ? S_FLUSH_HOLD : dispatch(fsm_state);
      end
      S_FLUSH_HOLD: if (fsm_state != IN_FLUSH) state_d = dispatch(fsm_state);
      S_LOCKED:     if (fsm_state != IN_LOCK && qual_q == QUAL_LAST) state_d = S_FLUSH_REQ;
      default:      state_d = S_IDLE;
    endcase

    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_STALL_HOLD || state_q == S_FLUSH_REQ || state_q == S_FLUSH_DRAIN))
      cnt_d = cnt_q + CNT_W'(1);

    qual_d = '0;
    if (state_q == S_LOCKED && state_d == S_LOCKED && fsm_state != IN_LOCK)
      qual_d = qual_q + CNT_W'(1);
  end

  // Output decode of the next state; clr_stats beats a same-cycle increment
  always_comb begin
    pipe_stall_d  = (state_d != S_IDLE);
    flush_req_d   = (state_d == S_FLUSH_REQ);
    lock_active_d = (state_d == S_LOCKED);
    escalate_d    = esc_c;
    flush_fault_d = flush_fault | timeout_c;
    flush_count_d = flush_count;
    lock_count_d  = lock_count;
    if (clr_stats) begin
      flush_count_d = '0;
      lock_count_d  = '0;
    end else begin
      if (state_d == S_FLUSH_DRAIN && state_q != S_FLUSH_DRAIN && flush_count != STAT_MAX)
        flush_count_d = flush_count + STAT_W'(1);
      if (state_d == S_LOCKED && state_q != S_LOCKED && lock_count != STAT_MAX)
        lock_count_d = lock_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_overlay_action_sequencer.sv
// Directed test-plan steps followed by random traffic, all checked every cycle against a
// mode/dwell-time reference model of the sequencer rules.
module tb_overlay_action_sequencer;

  localparam int unsigned MIN_STALL     = 4;
  localparam int unsigned STALL_TIMEOUT = 64;
  localparam int unsigned ACK_TIMEOUT   = 32;
  localparam int unsigned DRAIN_CYCLES  = 3;
  localparam int unsigned UNLOCK_QUAL   = 8;

  // Model modes carry their externally visible seq_state codes
  localparam int M_IDLE = 0, M_STALL = 1, M_REQ = 2, M_DRAIN = 3, M_HOLD = 4, M_LOCK = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fsm_state = 2'b00;
  logic       flush_ack = 1'b0;
  logic       clr_stats = 1'b0;
  logic       pipe_stall, flush_req, lock_active, escalate_pulse, flush_fault;
  logic [2:0] seq_state;
  logic [7:0] flush_count, lock_count;

  int vectors = 0;
  int miscompares = 0;

  int m_mode = M_IDLE;
  int m_dwell = 0;
  int m_run = 0;
  int m_fc = 0;
  int m_lc = 0;
  bit m_fault = 1'b0;
  bit m_esc = 1'b0;

  overlay_action_sequencer #(
    .MIN_STALL(MIN_STALL), .STALL_TIMEOUT(STALL_TIMEOUT), .ACK_TIMEOUT(ACK_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES), .UNLOCK_QUAL(UNLOCK_QUAL)
  ) dut (
    .clk(clk), .rst(rst), .fsm_state(fsm_state), .flush_ack(flush_ack), .clr_stats(clr_stats),
    .pipe_stall(pipe_stall), .flush_req(flush_req), .lock_active(lock_active),
    .escalate_pulse(escalate_pulse), .flush_fault(flush_fault), .seq_state(seq_state),
    .flush_count(flush_count), .lock_count(lock_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int route(input logic [1:0] f);
    if (f == 2'b11) return M_LOCK;
    if (f == 2'b10) return M_REQ;
    if (f == 2'b01) return M_STALL;
    return M_IDLE;
  endfunction

  // Reference: where the block goes after a cycle, given how long it has dwelt in its mode
  task automatic model_step(input logic [1:0] f, input logic a, input logic c, input logic r);
    int nxt;
    if (r) begin
      m_mode = M_IDLE; m_dwell = 0; m_run = 0; m_fc = 0; m_lc = 0; m_fault = 0; m_esc = 0;
      return;
    end
    nxt = m_mode;
    m_esc = 0;
    case (m_mode)
      M_IDLE:  nxt = route(f);
      M_STALL: begin
        if (f == 2'b11 || f == 2'b10) nxt = route(f);
        else if (f == 2'b00 && m_dwell + 1 >= MIN_STALL) nxt = M_IDLE;
        else if (f == 2'b01 && m_dwell + 1 == STALL_TIMEOUT) begin nxt = M_REQ; m_esc = 1; end
      end
      M_REQ: begin
        if (a) nxt = M_DRAIN;
        else if (m_dwell + 1 == ACK_TIMEOUT) begin nxt = M_LOCK; m_fault = 1; end
      end
      M_DRAIN: if (m_dwell + 1 == DRAIN_CYCLES) nxt = (f == 2'b10) ? M_HOLD : route(f);
      M_HOLD:  if (f != 2'b10) nxt = route(f);
      default: if (f != 2'b11 && m_run + 1 == UNLOCK_QUAL) nxt = M_REQ;
    endcase
    if (m_mode == M_LOCK && nxt == M_LOCK) m_run = (f == 2'b11) ? 0 : m_run + 1;
    else m_run = 0;
    if (c) begin
      m_fc = 0; m_lc = 0;
    end else begin
      if (nxt == M_DRAIN && m_mode != M_DRAIN && m_fc < 255) m_fc++;
      if (nxt == M_LOCK && m_mode != M_LOCK && m_lc < 255) m_lc++;
    end
    m_dwell = (nxt == m_mode) ? m_dwell + 1 : 0;
    m_mode = nxt;
  endtask

  task automatic cycle(input logic [1:0] f, input logic a, input logic c, input logic r);
    fsm_state = f; flush_ack = a; clr_stats = c; rst = r;
    @(posedge clk);
    model_step(f, a, c, r);
    #1;
    chk("seq_state", 32'(seq_state), 32'(m_mode));
    chk("pipe_stall", 32'(pipe_stall), 32'(m_mode != M_IDLE));
    chk("flush_req", 32'(flush_req), 32'(m_mode == M_REQ));
    chk("lock_active", 32'(lock_active), 32'(m_mode == M_LOCK));
    chk("escalate_pulse", 32'(escalate_pulse), 32'(m_esc));
    chk("flush_fault", 32'(flush_fault), 32'(m_fault));
    chk("flush_count", 32'(flush_count), 32'(m_fc));
    chk("lock_count", 32'(lock_count), 32'(m_lc));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_seq"}, 32'(seq_state), 32'd0);
    chk({tag, "_stall"}, 32'(pipe_stall), 32'd0);
    chk({tag, "_req"}, 32'(flush_req), 32'd0);
    chk({tag, "_lock"}, 32'(lock_active), 32'd0);
    chk({tag, "_esc"}, 32'(escalate_pulse), 32'd0);
    chk({tag, "_fault"}, 32'(flush_fault), 32'd0);
    chk({tag, "_fcnt"}, 32'(flush_count), 32'd0);
    chk({tag, "_lcnt"}, 32'(lock_count), 32'd0);
  endtask

  initial begin
    int n, esc_at, esc_total;
    logic [1:0] f;
    int run;

    // Reset
    cycle(2'b00, 0, 0, 1);
    cycle(2'b00, 0, 0, 1);
    check_zero("reset");

    // One STALL cycle then OK: minimum stall of 4 cycles
    cycle(2'b01, 0, 0, 0);
    n = int'(pipe_stall);
    for (int i = 0; i < 9; i++) begin
      cycle(2'b00, 0, 0, 0);
      n += int'(pipe_stall);
    end
    chk("min_stall_len", 32'(n), 32'd4);
    chk("min_stall_idle", 32'(seq_state), 32'd0);

    // Held STALL escalates after 64 STALL_HOLD cycles
    esc_at = 0;
    for (int k = 1; k <= 100 && esc_at == 0; k++) begin
      cycle(2'b01, 0, 0, 0);
      if (escalate_pulse) esc_at = k;
    end
    chk("esc_cycle", 32'(esc_at), 32'd65);
    chk("esc_flush_req", 32'(flush_req), 32'd1);
    esc_total = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(2'b01, 0, 0, 0);
      esc_total += int'(escalate_pulse);
    end
    chk("esc_single", 32'(esc_total), 32'd0);
    cycle(2'b00, 1, 0, 0);
    chk("ack_drain", 32'(seq_state), 32'd3);
    chk("ack_req_low", 32'(flush_req), 32'd0);
    chk("ack_fcnt", 32'(flush_count), 32'd1);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 0, 0, 0);
      n += int'(seq_state == 3'd3);
    end
    chk("drain_len", 32'(n), 32'd3);
    chk("drain_idle", 32'(seq_state), 32'd0);

    // Ack timeout: fault and lock
    for (int i = 0; i < 32; i++) cycle(2'b10, 0, 0, 0);
    chk("pre_timeout_fault", 32'(flush_fault), 32'd0);
    chk("pre_timeout_req", 32'(flush_req), 32'd1);
    cycle(2'b10, 0, 0, 0);
    chk("timeout_fault", 32'(flush_fault), 32'd1);
    chk("timeout_locked", 32'(seq_state), 32'd5);
    chk("timeout_lcnt", 32'(lock_count), 32'd1);
    for (int i = 0; i < 12; i++) cycle(2'b00, 0, 0, 0);
    chk("fault_sticky", 32'(flush_fault), 32'd1);

    // Unlock qualification
    cycle(2'b00, 0, 0, 1);
    check_zero("rst_clears_fault");
    for (int i = 0; i < 10; i++) cycle(2'b11, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(2'b00, 0, 0, 0);
    cycle(2'b11, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(2'b00, 0, 0, 0);
    chk("qual_hold", 32'(seq_state), 32'd5);
    cycle(2'b00, 0, 0, 0);
    chk("qual_exit", 32'(seq_state), 32'd2);
    chk("qual_exit_req", 32'(flush_req), 32'd1);

    // Reset mid FLUSH_REQ and mid LOCKED
    cycle(2'b11, 0, 0, 1);
    check_zero("rst_mid_req");
    for (int i = 0; i < 3; i++) cycle(2'b11, 0, 0, 0);
    chk("relock", 32'(lock_active), 32'd1);
    cycle(2'b11, 0, 0, 1);
    check_zero("rst_mid_lock");

    // Flush count saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      cycle(2'b10, 0, 0, 0);
      cycle(2'b00, 1, 0, 0);
      for (int j = 0; j < 3; j++) cycle(2'b00, 0, 0, 0);
    end
    chk("fcnt_sat", 32'(flush_count), 32'd255);
    cycle(2'b10, 0, 0, 0);
    cycle(2'b00, 1, 1, 0);
    chk("clr_wins", 32'(flush_count), 32'd0);
    for (int j = 0; j < 3; j++) cycle(2'b00, 0, 0, 0);
    cycle(2'b10, 0, 0, 0);
    cycle(2'b10, 1, 0, 0);
    chk("fcnt_after_clr", 32'(flush_count), 32'd1);
    for (int j = 0; j < 3; j++) cycle(2'b10, 0, 0, 0);
    chk("flush_hold", 32'(seq_state), 32'd4);
    cycle(2'b00, 0, 1, 0);
    chk("clr_stats", 32'(flush_count), 32'd0);

    // Random traffic in runs so dwell-time rules are exercised
    run = 0;
    f = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        n = int'($urandom_range(0, 99));
        f = (n < 45) ? 2'b00 : (n < 72) ? 2'b01 : (n < 88) ? 2'b10 : 2'b11;
        run = int'($urandom_range(1, 14));
      end
      run--;
      cycle(f, $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
